// File: rtl/texel_pkg.sv
// texel_pkg: fetch FSM states, Q4.12 RGBA texel type, RGBA5652 field positions
package texel_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, PRESENT} fetch_state_t;
  typedef struct packed {
    logic [15:0] r;
    logic [15:0] g;
    logic [15:0] b;
    logic [15:0] a;
  } q412_rgba_t;
  localparam int R_LSB = 13;
  localparam int G_LSB = 7;
  localparam int B_LSB = 2;
  localparam int A_LSB = 0;
  localparam logic [15:0] Q412_ONE = 16'h1000;
endpackage

// File: rtl/texel_quad_fetch_if.sv
// texel_quad_fetch_if: request, cache read port and quad output; master = fetch block, slave = environment
interface texel_quad_fetch_if #(parameter int IDX_W = 10);
  logic               req_valid;
  logic               req_ready;
  logic               req_bilinear;
  logic [4*IDX_W-1:0] req_idx;
  logic               cache_stall;
  logic               cache_rd_en;
  logic [IDX_W-1:0]   cache_rd_idx;
  logic [17:0]        cache_rd_data;
  logic               out_valid;
  logic               out_ready;
  logic [255:0]       out_texels;
  modport master (
    input  req_valid, req_bilinear, req_idx, cache_stall, cache_rd_data, out_ready,
    output req_ready, cache_rd_en, cache_rd_idx, out_valid, out_texels
  );
  modport slave (
    output req_valid, req_bilinear, req_idx, cache_stall, cache_rd_data, out_ready,
    input  req_ready, cache_rd_en, cache_rd_idx, out_valid, out_texels
  );
endinterface

// File: rtl/texel_promote.sv
// texel_promote: combinational RGBA5652 (rgba) to Q4.12 RGBA (q) by bit replication
module texel_promote
  import texel_pkg::*;
(
  input  logic [17:0] rgba,
  output q412_rgba_t  q
);
  logic [4:0] r, b;
  logic [5:0] g;
  logic [1:0] a;
  assign r = rgba[R_LSB +: 5];
  assign g = rgba[G_LSB +: 6];
  assign b = rgba[B_LSB +: 5];
  assign a = rgba[A_LSB +: 2];
  always_comb begin
    q.r = {3'b0, r, r, r[4:2]};
    q.g = {3'b0, g, g, 1'b0};
    q.b = {3'b0, b, b, b[4:2]};
    q.a = a == 2'd3 ? Q412_ONE : a == 2'd2 ? 16'h0AAA : a == 2'd1 ? 16'h0555 : 16'h0000;
  end
endmodule

// File: rtl/texel_quad_fetch.sv
// texel_quad_fetch: issues 4 (bilinear) or 1 (nearest) cache reads per request, promotes and presents a Q4.12 quad; clk, rst_n, bus (texel_quad_fetch_if.master)
module texel_quad_fetch
  import texel_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input logic                clk,
  input logic                rst_n,
  texel_quad_fetch_if.master bus
);
  fetch_state_t       state_q, state_d;
  logic [1:0]         issue_cnt_q, issue_cnt_d, cap_cnt_q, cap_cnt_d, last;
  logic               bilinear_q, bilinear_d, rd_pend_q, rd_pend_d;
  logic [4*IDX_W-1:0] idx_q, idx_d;
  logic [255:0]       texels_q, texels_d;
  q412_rgba_t         px;
  texel_promote u_promote (.rgba(bus.cache_rd_data), .q(px));
  assign last             = bilinear_q ? 2'd3 : 2'd0;
  assign bus.req_ready    = rst_n && state_q == IDLE;
  assign bus.cache_rd_en  = state_q == ISSUE && !bus.cache_stall;
  assign bus.cache_rd_idx = idx_q[32'(issue_cnt_q) * IDX_W +: IDX_W];
  assign bus.out_valid    = state_q == PRESENT;
  assign bus.out_texels   = texels_q;
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    bilinear_d  = bilinear_q;
    idx_d       = idx_q;
    texels_d    = texels_q;
    rd_pend_d   = bus.cache_rd_en;
    if (rd_pend_q) begin
      for (int i = 0; i < 4; i++)
        if (!bilinear_q || cap_cnt_q == 2'(i)) texels_d[64*i +: 64] = px;
      cap_cnt_d = cap_cnt_q + {1'b0, cap_cnt_q != 2'd3};
    end
    case (state_q)
      IDLE: if (bus.req_valid && bus.req_ready) begin
        state_d     = ISSUE;
        bilinear_d  = bus.req_bilinear;
        idx_d       = bus.req_idx;
        issue_cnt_d = 2'd0;
        cap_cnt_d   = 2'd0;
      end
      ISSUE: if (!bus.cache_stall) begin
        issue_cnt_d = issue_cnt_q + {1'b0, issue_cnt_q != 2'd3};
        state_d     = issue_cnt_q == last ? DRAIN : ISSUE;
      end
      DRAIN:   state_d = rd_pend_q && cap_cnt_q == last ? PRESENT : DRAIN;
      PRESENT: state_d = bus.out_ready ? IDLE : PRESENT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= 2'd0;
      cap_cnt_q   <= 2'd0;
      bilinear_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      idx_q       <= '0;
      texels_q    <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      bilinear_q  <= bilinear_d;
      rd_pend_q   <= rd_pend_d;
      idx_q       <= idx_d;
      texels_q    <= texels_d;
    end
  end
endmodule

// File: tb/tb_texel_quad_fetch.sv
// tb_texel_quad_fetch: directed self-checking bench for texel_quad_fetch with a small cache model
module tb_texel_quad_fetch;
  logic clk = 0;
  logic rst_n = 0;
  texel_quad_fetch_if #(.IDX_W(10)) bus ();
  texel_quad_fetch #(.IDX_W(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [17:0] mem [0:7];
  int n_chk = 0;
  int n_pass = 0;
  int n_iss, vcyc;
  int iss_idx [0:7];
  int iss_cyc [0:7];
  localparam logic [63:0] TA = 64'h1084_0000_0000_1000;
  localparam logic [63:0] TG = 64'h0000_1FFE_0000_0000;
  localparam logic [63:0] TB = 64'h0000_0000_0108_0AAA;
  localparam logic [63:0] TN = 64'h0000_0000_0000_0555;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask
  function automatic logic [31:0] pack_idx();
    logic [31:0] v = 0;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = 8'(iss_idx[i]);
    return v;
  endfunction
  function automatic logic [31:0] pack_cyc();
    logic [31:0] v = 0;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = 8'(iss_cyc[i]);
    return v;
  endfunction
  task automatic run(input logic bil, input logic [39:0] idx, input int s_lo, input int s_hi);
    logic pend;
    logic [9:0] pidx;
    pend = 0;
    pidx = 0;
    n_iss = 0;
    vcyc = 0;
    for (int i = 0; i < 8; i++) begin
      iss_idx[i] = 0;
      iss_cyc[i] = 0;
    end
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1;
    bus.req_bilinear = bil;
    bus.req_idx = idx;
    @(posedge clk);
    for (int k = 1; k <= 40 && vcyc == 0; k++) begin
      #1;
      bus.req_valid = 0;
      bus.req_idx = '1;
      bus.cache_rd_data = pend ? mem[pidx[2:0]] : 18'h0;
      bus.cache_stall = k >= s_lo && k <= s_hi;
      @(negedge clk);
      pend = bus.cache_rd_en;
      pidx = bus.cache_rd_idx;
      if (pend && n_iss < 8) begin
        iss_idx[n_iss] = int'(pidx);
        iss_cyc[n_iss] = k;
        n_iss++;
      end
      if (bus.out_valid) vcyc = k;
      else @(posedge clk);
    end
    bus.cache_stall = 0;
  endtask
  task automatic release_quad(input string tag, input logic [255:0] exp);
    bus.out_ready = 1;
    @(posedge clk);
    #1;
    bus.out_ready = 0;
    chk({tag, "_idle_ready"}, bus.req_ready, 1);
    chk({tag, "_idle_valid"}, bus.out_valid, 0);
    chk({tag, "_held"}, bus.out_texels, exp);
  endtask
  initial begin
    mem[0] = 18'h20003; mem[1] = 18'h00000; mem[2] = 18'h01F80; mem[3] = 18'h00006;
    mem[4] = 18'h00006; mem[5] = 18'h00001; mem[6] = 18'h20003; mem[7] = 18'h01F80;
    bus.req_valid = 0;
    bus.req_bilinear = 0;
    bus.req_idx = '0;
    bus.cache_stall = 0;
    bus.cache_rd_data = '0;
    bus.out_ready = 0;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rd_en", bus.cache_rd_en, 0);
    chk("rst_rd_idx", bus.cache_rd_idx, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_texels", bus.out_texels, 0);
    #22 rst_n = 1;
    run(1, {10'd3, 10'd2, 10'd1, 10'd0}, 0, 0);
    chk("bil_n_iss", n_iss, 4);
    chk("bil_idx", pack_idx(), 32'h03020100);
    chk("bil_cyc", pack_cyc(), 32'h04030201);
    chk("bil_vcyc", vcyc, 6);
    chk("bil_texels", bus.out_texels, {TB, TG, 64'h0, TA});
    chk("promote_t0", bus.out_texels[63:0], TA);
    release_quad("bil", {TB, TG, 64'h0, TA});
    run(0, {10'd1, 10'd3, 10'd6, 10'd5}, 0, 0);
    chk("nn_n_iss", n_iss, 1);
    chk("nn_idx", pack_idx(), 32'h00000005);
    chk("nn_cyc", pack_cyc(), 32'h00000001);
    chk("nn_vcyc", vcyc, 3);
    chk("nn_texels", bus.out_texels, {4{TN}});
    release_quad("nn", {4{TN}});
    run(1, {10'd4, 10'd5, 10'd6, 10'd7}, 3, 4);
    chk("stl_n_iss", n_iss, 4);
    chk("stl_idx", pack_idx(), 32'h04050607);
    chk("stl_cyc", pack_cyc(), 32'h06050201);
    chk("stl_vcyc", vcyc, 8);
    chk("stl_texels", bus.out_texels, {TB, TN, TA, TG});
    bus.req_valid = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_ready", bus.req_ready, 0);
      chk("hold_texels", bus.out_texels, {TB, TN, TA, TG});
    end
    bus.out_ready = 1;
    @(posedge clk);
    #1;
    bus.req_valid = 0;
    bus.out_ready = 0;
    chk("hold_idle_ready", bus.req_ready, 1);
    chk("hold_idle_valid", bus.out_valid, 0);
    @(negedge clk);
    bus.req_valid = 1;
    bus.req_bilinear = 1;
    bus.req_idx = {10'd3, 10'd2, 10'd1, 10'd0};
    @(posedge clk);
    #1;
    bus.req_valid = 0;
    @(negedge clk);
    chk("rstop_rd_en_c1", bus.cache_rd_en, 1);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("rstop_rd_en", bus.cache_rd_en, 0);
    chk("rstop_out_valid", bus.out_valid, 0);
    chk("rstop_req_ready", bus.req_ready, 0);
    chk("rstop_texels", bus.out_texels, 0);
    @(negedge clk);
    rst_n = 1;
    bus.cache_rd_data = '0;
    #1;
    chk("rstop_rel_ready", bus.req_ready, 1);
    run(0, {10'd7, 10'd6, 10'd5, 10'd2}, 0, 0);
    chk("post_n_iss", n_iss, 1);
    chk("post_idx", pack_idx(), 32'h00000002);
    chk("post_vcyc", vcyc, 3);
    chk("post_texels", bus.out_texels, {4{TG}});
    release_quad("post", {4{TG}});
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
